// File: rtl/edf_ic_pkg.sv
// Shared types for the EDF interrupt arbiter: FSM state encoding and default timestamp width.
package edf_ic_pkg;

   localparam int unsigned DefTsWidth = 64;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_PRESENT,
      ST_CLAIM
   } edf_arb_state_e;

endpackage

// File: rtl/edf_dl_cmp.sv
// Combinational "a earlier than b" on free-running timestamps; zero latency, no flow control.
module edf_dl_cmp #(
   parameter int unsigned W = 64
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         earlier_o
);

   logic [W-1:0] diff;

   // Sign of the modular difference tolerates a wrapping time base.
   assign diff      = a_i - b_i;
   assign earlier_o = diff[W-1];

endmodule

// File: rtl/edf_arbiter.sv
// Earliest-deadline-first pick over NrIrqs pending sources; valid NrIrqs+1 cycles after pending seen in IDLE.
// Selection held stable under valid/ready backpressure, then a one-cycle claim pulse clears the winner.
module edf_arbiter
   import edf_ic_pkg::*;
#(
   parameter  int unsigned NrIrqs  = 4,
   parameter  int unsigned TsWidth = DefTsWidth,
   localparam int unsigned IdWidth = $clog2(NrIrqs)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      en_i,
   input  logic [TsWidth-1:0]        mtime_i,
   input  logic [NrIrqs-1:0]         ip_i,
   input  logic [NrIrqs*TsWidth-1:0] dl_i,
   output logic [IdWidth-1:0]        irq_id_o,
   output logic [TsWidth-1:0]        irq_dl_o,
   output logic                      irq_late_o,
   output logic                      irq_valid_o,
   input  logic                      irq_ready_i,
   output logic                      claim_o,
   output logic [IdWidth-1:0]        claim_id_o
);

   edf_arb_state_e     state_q;
   logic [IdWidth-1:0] scan_idx_q;
   logic               best_vld_q, best_vld_d;
   logic [IdWidth-1:0] best_id_q, best_id_d;
   logic [TsWidth-1:0] best_dl_q, best_dl_d;

   logic               irq_valid_q, irq_late_q, claim_q;
   logic [IdWidth-1:0] irq_id_q, claim_id_q;
   logic [TsWidth-1:0] irq_dl_q;

   logic [TsWidth-1:0] dl_arr [NrIrqs];
   logic [TsWidth-1:0] cand_dl;
   logic               cand_earlier, late_d, scan_last;

   for (genvar g = 0; g < NrIrqs; g++) begin : g_dl
      assign dl_arr[g] = dl_i[g*TsWidth +: TsWidth];
   end

   assign cand_dl   = dl_arr[scan_idx_q];
   assign scan_last = (scan_idx_q == IdWidth'(NrIrqs - 1));

   edf_dl_cmp #(.W(TsWidth)) u_cmp_scan (
      .a_i       (cand_dl),
      .b_i       (best_dl_q),
      .earlier_o (cand_earlier)
   );

   // Lateness is judged on the post-update best so the last scanned source counts.
   edf_dl_cmp #(.W(TsWidth)) u_cmp_late (
      .a_i       (best_dl_d),
      .b_i       (mtime_i),
      .earlier_o (late_d)
   );

   // Strict "earlier" keeps the lower ID on ties since IDs are scanned ascending.
   always_comb begin
      best_vld_d = best_vld_q;
      best_id_d  = best_id_q;
      best_dl_d  = best_dl_q;
      if (ip_i[scan_idx_q] && (!best_vld_q || cand_earlier)) begin
         best_vld_d = 1'b1;
         best_id_d  = scan_idx_q;
         best_dl_d  = cand_dl;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         scan_idx_q  <= '0;
         best_vld_q  <= 1'b0;
         best_id_q   <= '0;
         best_dl_q   <= '0;
         irq_valid_q <= 1'b0;
         irq_id_q    <= '0;
         irq_dl_q    <= '0;
         irq_late_q  <= 1'b0;
         claim_q     <= 1'b0;
         claim_id_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (en_i && |ip_i) begin
                  state_q    <= ST_SCAN;
                  scan_idx_q <= '0;
                  best_vld_q <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (!en_i) begin
                  state_q <= ST_IDLE;
               end else begin
                  best_vld_q <= best_vld_d;
                  best_id_q  <= best_id_d;
                  best_dl_q  <= best_dl_d;
                  if (!scan_last) begin
                     scan_idx_q <= scan_idx_q + IdWidth'(1);
                  end else if (best_vld_d) begin
                     state_q     <= ST_PRESENT;
                     irq_valid_q <= 1'b1;
                     irq_id_q    <= best_id_d;
                     irq_dl_q    <= best_dl_d;
                     irq_late_q  <= late_d;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_PRESENT: begin
               if (irq_ready_i) begin
                  state_q     <= ST_CLAIM;
                  irq_valid_q <= 1'b0;
                  claim_q     <= 1'b1;
                  claim_id_q  <= irq_id_q;
               end
            end
            ST_CLAIM: begin
               claim_q <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign irq_valid_o = irq_valid_q;
   assign irq_id_o    = irq_id_q;
   assign irq_dl_o    = irq_dl_q;
   assign irq_late_o  = irq_late_q;
   assign claim_o     = claim_q;
   assign claim_id_o  = claim_id_q;

endmodule

// File: tb/tb_edf_arbiter.sv
// Directed-vector bench for edf_arbiter with NrIrqs=4, TsWidth=64.
module tb_edf_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned TW = 64;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          en_i;
   logic [TW-1:0] mtime_i;
   logic [N-1:0]  ip_i;
   logic [N*TW-1:0] dl_i;
   logic [1:0]    irq_id_o;
   logic [TW-1:0] irq_dl_o;
   logic          irq_late_o;
   logic          irq_valid_o;
   logic          irq_ready_i;
   logic          claim_o;
   logic [1:0]    claim_id_o;

   int vectors     = 0;
   int miscompares = 0;

   edf_arbiter #(.NrIrqs(N), .TsWidth(TW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .mtime_i     (mtime_i),
      .ip_i        (ip_i),
      .dl_i        (dl_i),
      .irq_id_o    (irq_id_o),
      .irq_dl_o    (irq_dl_o),
      .irq_late_o  (irq_late_o),
      .irq_valid_o (irq_valid_o),
      .irq_ready_i (irq_ready_i),
      .claim_o     (claim_o),
      .claim_id_o  (claim_id_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Returns number of rising edges until valid is seen, or -1 on timeout.
   task automatic wait_valid(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (irq_valid_o) begin
            n = i;
            break;
         end
      end
   endtask

   // Let a pending handshake complete and park the FSM in IDLE.
   task automatic drain();
      ip_i        = '0;
      irq_ready_i = 1'b1;
      repeat (3) step();
      irq_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; en_i = 1'b1; ip_i = '0; dl_i = '0; mtime_i = '0; irq_ready_i = 1'b0;
      repeat (2) step();
      vectors++; if (irq_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", irq_valid_o); end
      vectors++; if (claim_o !== 1'b0) begin miscompares++; $display("FAIL reset_claim got %b want 0", claim_o); end
      vectors++; if (irq_id_o !== 2'd0) begin miscompares++; $display("FAIL reset_id got %0d want 0", irq_id_o); end
      vectors++; if (claim_id_o !== 2'd0) begin miscompares++; $display("FAIL reset_claim_id got %0d want 0", claim_id_o); end
      vectors++; if (irq_dl_o !== 64'd0) begin miscompares++; $display("FAIL reset_dl got %0h want 0", irq_dl_o); end
      vectors++; if (irq_late_o !== 1'b0) begin miscompares++; $display("FAIL reset_late got %b want 0", irq_late_o); end
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int n;
      dl_i = '0;
      dl_i[1*TW +: TW] = 64'd500;
      dl_i[3*TW +: TW] = 64'd200;
      mtime_i = 64'd100; irq_ready_i = 1'b1; ip_i = 4'b1010;
      wait_valid(20, n);
      vectors++; if (n != 5) begin miscompares++; $display("FAIL basic_latency got %0d want 5", n); end
      vectors++; if (irq_id_o !== 2'd3) begin miscompares++; $display("FAIL basic_id got %0d want 3", irq_id_o); end
      vectors++; if (irq_dl_o !== 64'd200) begin miscompares++; $display("FAIL basic_dl got %0d want 200", irq_dl_o); end
      vectors++; if (irq_late_o !== 1'b0) begin miscompares++; $display("FAIL basic_late got %b want 0", irq_late_o); end
      ip_i = '0;
      step();
      vectors++; if (claim_o !== 1'b1) begin miscompares++; $display("FAIL basic_claim got %b want 1", claim_o); end
      vectors++; if (claim_id_o !== 2'd3) begin miscompares++; $display("FAIL basic_claim_id got %0d want 3", claim_id_o); end
      vectors++; if (irq_valid_o !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop got %b want 0", irq_valid_o); end
      step();
      vectors++; if (claim_o !== 1'b0) begin miscompares++; $display("FAIL basic_claim_width got %b want 0", claim_o); end
      drain();
   endtask

   task automatic test_tie();
      int n;
      dl_i = '0;
      dl_i[1*TW +: TW] = 64'd300;
      dl_i[2*TW +: TW] = 64'd300;
      mtime_i = 64'd100; irq_ready_i = 1'b0; ip_i = 4'b0110;
      wait_valid(20, n);
      vectors++; if (n != 5) begin miscompares++; $display("FAIL tie_latency got %0d want 5", n); end
      vectors++; if (irq_id_o !== 2'd1) begin miscompares++; $display("FAIL tie_id got %0d want 1", irq_id_o); end
      vectors++; if (irq_dl_o !== 64'd300) begin miscompares++; $display("FAIL tie_dl got %0d want 300", irq_dl_o); end
      drain();
   endtask

   task automatic test_wrap();
      int n;
      dl_i = '0;
      dl_i[0*TW +: TW] = 64'hFFFF_FFFF_FFFF_FFF0;
      dl_i[2*TW +: TW] = 64'h10;
      mtime_i = 64'hFFFF_FFFF_FFFF_FF00; irq_ready_i = 1'b0; ip_i = 4'b0101;
      wait_valid(20, n);
      vectors++; if (n != 5) begin miscompares++; $display("FAIL wrap_latency got %0d want 5", n); end
      vectors++; if (irq_id_o !== 2'd0) begin miscompares++; $display("FAIL wrap_id got %0d want 0", irq_id_o); end
      vectors++; if (irq_late_o !== 1'b0) begin miscompares++; $display("FAIL wrap_late got %b want 0", irq_late_o); end
      drain();
      mtime_i = 64'h20; ip_i = 4'b0100;
      wait_valid(20, n);
      vectors++; if (irq_id_o !== 2'd2) begin miscompares++; $display("FAIL late_id got %0d want 2", irq_id_o); end
      vectors++; if (irq_late_o !== 1'b1) begin miscompares++; $display("FAIL late_flag got %b want 1", irq_late_o); end
      vectors++; if (irq_dl_o !== 64'h10) begin miscompares++; $display("FAIL late_dl got %0h want 10", irq_dl_o); end
      drain();
   endtask

   task automatic test_hold();
      int n;
      int bad;
      dl_i = '0;
      dl_i[2*TW +: TW] = 64'd50;
      mtime_i = 64'd10; irq_ready_i = 1'b0; ip_i = 4'b0100;
      wait_valid(20, n);
      vectors++; if (n != 5) begin miscompares++; $display("FAIL hold_latency got %0d want 5", n); end
      ip_i = '0; en_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (irq_valid_o !== 1'b1 || irq_id_o !== 2'd2 || irq_dl_o !== 64'd50 || claim_o !== 1'b0) bad++;
      end
      vectors++; if (bad != 0) begin miscompares++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
      irq_ready_i = 1'b1;
      step();
      vectors++; if (claim_o !== 1'b1) begin miscompares++; $display("FAIL hold_claim got %b want 1", claim_o); end
      vectors++; if (claim_id_o !== 2'd2) begin miscompares++; $display("FAIL hold_claim_id got %0d want 2", claim_id_o); end
      irq_ready_i = 1'b0; en_i = 1'b1;
      repeat (2) step();
   endtask

   task automatic test_reset_present();
      int n;
      int claims;
      dl_i = '0;
      dl_i[1*TW +: TW] = 64'd77;
      mtime_i = 64'd10; irq_ready_i = 1'b0; ip_i = 4'b0010;
      wait_valid(20, n);
      vectors++; if (irq_id_o !== 2'd1) begin miscompares++; $display("FAIL rstp_id got %0d want 1", irq_id_o); end
      rst_i = 1'b1; ip_i = '0; irq_ready_i = 1'b1;
      step();
      vectors++; if (irq_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstp_valid got %b want 0", irq_valid_o); end
      rst_i = 1'b0;
      claims = (claim_o === 1'b1) ? 1 : 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (claim_o !== 1'b0 || irq_valid_o !== 1'b0) claims++;
      end
      vectors++; if (claims != 0) begin miscompares++; $display("FAIL rstp_no_claim got %0d bad cycles want 0", claims); end
      irq_ready_i = 1'b0;
   endtask

   task automatic test_scan_drop();
      int n;
      int seen;
      dl_i = '0;
      dl_i[3*TW +: TW] = 64'd40;
      dl_i[0*TW +: TW] = 64'd90;
      mtime_i = 64'd10; irq_ready_i = 1'b1; ip_i = 4'b1000;
      step();
      ip_i = '0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (irq_valid_o !== 1'b0 || claim_o !== 1'b0) seen++;
      end
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL drop_valid got %0d bad cycles want 0", seen); end
      ip_i = 4'b0001;
      wait_valid(20, n);
      vectors++; if (n != 5) begin miscompares++; $display("FAIL drop_rearm_latency got %0d want 5", n); end
      vectors++; if (irq_id_o !== 2'd0) begin miscompares++; $display("FAIL drop_rearm_id got %0d want 0", irq_id_o); end
      drain();
   endtask

   task automatic test_disable();
      int seen;
      dl_i = '0;
      dl_i[2*TW +: TW] = 64'd40;
      en_i = 1'b0; irq_ready_i = 1'b1; ip_i = 4'b0100;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (irq_valid_o !== 1'b0) seen++;
      end
      vectors++; if (seen != 0) begin miscompares++; $display("FAIL disabled_valid got %0d bad cycles want 0", seen); end
      ip_i = '0; en_i = 1'b1; irq_ready_i = 1'b0;
      step();
   endtask

   initial begin
      @(negedge clk_i);
      test_reset();
      test_basic();
      test_tie();
      test_wrap();
      test_hold();
      test_reset_present();
      test_scan_drop();
      test_disable();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
